sky130_ajc_ip__por_seq: RTL and testbench

//  Digital multi-domain power-on-reset sequencer: successor to single-rail POR timing logic.

---
 rtl/sky130_ajc_ip__por_seq.sv | 141 ++++++++++++++
 tb/tb_sky130_ajc_ip__por_seq.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sky130_ajc_ip__por_seq.sv
// sky130_ajc_ip__por_seq: multi-domain POR sequencer; deglitches supply-good inputs, holds,
// then releases per-domain resets in ascending order with a programmable stagger.
module sky130_ajc_ip__por_seq #(
   parameter int NCH       = 4,
   parameter int FILT_LEN  = 8,
   parameter int DLY_W     = 16,
   parameter int TMO_W     = 20,
   parameter int SHORT_DLY = 3
) (
   input  logic             osc_ck,
   input  logic             rst,
   input  logic [NCH-1:0]   pwup,
   input  logic [NCH-1:0]   ch_en,
   input  logic [DLY_W-1:0] por_dly,
   input  logic [DLY_W-1:0] stagger_dly,
   input  logic [TMO_W-1:0] tmo_lim,
   input  logic             force_pdn,
   input  logic             force_short_oneshot,
   output logic [NCH-1:0]   por,
   output logic [NCH-1:0]   porb,
   output logic [NCH-1:0]   pwup_filt,
   output logic [2:0]       state,
   output logic             startup_timed_out,
   output logic             por_timed_out
);
   localparam int FW = $clog2(FILT_LEN + 1);
   typedef enum logic [2:0] {
      IDLE = 3'd0, WAIT_GOOD = 3'd1, HOLD = 3'd2, STAGGER = 3'd3, RUN = 3'd4, FAULT = 3'd5
   } state_t;
   state_t           state_q, state_d;
   logic [NCH-1:0]   s1_q, s2_q, por_q, por_d, por_sh;
   logic [FW-1:0]    cnt_q [NCH];
   logic [TMO_W-1:0] tmo_q, tmo_d, tmo_inc;
   logic [DLY_W-1:0] dly_q, dly_d, hold_ld, stag_ld;
   logic             sto_q, sto_d, ptm_q, ptm_d, all_good;
   always_ff @(posedge osc_ck or posedge rst) begin
      if (rst) begin
         s1_q <= '0;
         s2_q <= '0;
         for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
      end else begin
         s1_q <= pwup;
         s2_q <= s1_q;
         for (int i = 0; i < NCH; i++)
            cnt_q[i] <= !s2_q[i] ? '0 : (cnt_q[i] == FW'(FILT_LEN) ? cnt_q[i] : cnt_q[i] + 1'b1);
      end
   end
   for (genvar g = 0; g < NCH; g++) begin : g_filt
      assign pwup_filt[g] = cnt_q[g] == FW'(FILT_LEN);
   end
   assign all_good = &(pwup_filt | ~ch_en);
   assign tmo_inc  = &tmo_q ? tmo_q : tmo_q + 1'b1;
   assign hold_ld  = force_short_oneshot ? DLY_W'(SHORT_DLY) : por_dly;
   assign stag_ld  = force_short_oneshot ? DLY_W'(SHORT_DLY) : stagger_dly;
   // Releasing the next domain is a left shift: zeros enter from bit 0 upward.
   assign por_sh   = por_q << 1;
   always_comb begin
      state_d = state_q;
      tmo_d   = tmo_q;
      dly_d   = dly_q;
      por_d   = por_q;
      sto_d   = sto_q;
      ptm_d   = 1'b0;
      if (force_pdn) begin
         state_d = IDLE;
         tmo_d   = '0;
         dly_d   = '0;
         por_d   = '1;
         sto_d   = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               por_d   = '1;
               state_d = WAIT_GOOD;
            end
            WAIT_GOOD: begin
               por_d = '1;
               if (all_good) begin
                  state_d = HOLD;
                  dly_d   = hold_ld;
                  tmo_d   = '0;
               end else begin
                  tmo_d = tmo_inc;
                  sto_d = sto_q | (tmo_inc == tmo_lim);
               end
            end
            HOLD:
               if (!all_good) state_d = WAIT_GOOD;
               else if (dly_q <= DLY_W'(1)) begin
                  state_d = por_sh == '0 ? RUN : STAGGER;
                  por_d   = por_sh;
                  dly_d   = stag_ld;
                  ptm_d   = 1'b1;
               end else dly_d = dly_q - 1'b1;
            STAGGER:
               if (!all_good) begin
                  state_d = FAULT;
                  por_d   = '1;
               end else if (dly_q == '0) begin
                  state_d = por_sh == '0 ? RUN : STAGGER;
                  por_d   = por_sh;
                  dly_d   = stag_ld;
               end else dly_d = dly_q - 1'b1;
            RUN: begin
               por_d   = all_good ? '0 : '1;
               state_d = all_good ? RUN : FAULT;
            end
            FAULT: begin
               por_d   = '1;
               state_d = WAIT_GOOD;
            end
            default: begin
               por_d   = '1;
               state_d = IDLE;
            end
         endcase
      end
   end
   always_ff @(posedge osc_ck or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         tmo_q   <= '0;
         dly_q   <= '0;
         por_q   <= '1;
         sto_q   <= 1'b0;
         ptm_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tmo_q   <= tmo_d;
         dly_q   <= dly_d;
         por_q   <= por_d;
         sto_q   <= sto_d;
         ptm_q   <= ptm_d;
      end
   end
   assign por               = por_q;
   assign porb              = ~por_q;
   assign state             = state_q;
   assign startup_timed_out = sto_q;
   assign por_timed_out     = ptm_q;
endmodule

// File: tb/tb_sky130_ajc_ip__por_seq.sv
// tb_sky130_ajc_ip__por_seq: scenario tasks checking the POR sequencer against timing rules
// derived directly from the filter latency, hold length and stagger spacing.
module tb_sky130_ajc_ip__por_seq;
   localparam int N = 4;
   localparam int F = 8;
   logic        osc_ck = 1'b0;
   logic        rst;
   logic [3:0]  pwup, ch_en, por, porb, pwup_filt;
   logic [15:0] por_dly, stagger_dly;
   logic [19:0] tmo_lim;
   logic        force_pdn, force_short_oneshot, startup_timed_out, por_timed_out;
   logic [2:0]  state;
   int          errs = 0;
   int          chks = 0;

   always #5 osc_ck = ~osc_ck;

   sky130_ajc_ip__por_seq #(.NCH(N), .FILT_LEN(F), .DLY_W(16), .TMO_W(20), .SHORT_DLY(3)) dut (
      .osc_ck(osc_ck), .rst(rst), .pwup(pwup), .ch_en(ch_en), .por_dly(por_dly),
      .stagger_dly(stagger_dly), .tmo_lim(tmo_lim), .force_pdn(force_pdn),
      .force_short_oneshot(force_short_oneshot), .por(por), .porb(porb), .pwup_filt(pwup_filt),
      .state(state), .startup_timed_out(startup_timed_out), .por_timed_out(por_timed_out)
   );

   task automatic step();
      @(posedge osc_ck);
      #1;
   endtask

   // Leaves the sequencer one cycle into WAIT_GOOD with the given supply pattern applied.
   task automatic restart(input logic [3:0] p);
      rst = 1'b1; pwup = p; ch_en = 4'hF; force_pdn = 1'b0; force_short_oneshot = 1'b0;
      por_dly = 16'd10; stagger_dly = 16'd2; tmo_lim = 20'd1000;
      step();
      rst = 1'b0;
      step();
   endtask

   // all_good becomes visible lat cycles after the stimulus; HOLD follows one cycle later,
   // lasts max(d,1) cycles, then por[k] clears k*(s+1) cycles after the por_timed_out pulse.
   task automatic run_seq(input int lat, input logic [3:0] fb, input logic [3:0] fa,
                          input int d, input int s, input int stop, input logic sto_e);
      int tp;
      logic [3:0] ep, ef;
      logic [2:0] es;
      tp = lat + 1 + (d < 1 ? 1 : d);
      for (int n = 1; n <= stop; n++) begin
         step();
         for (int k = 0; k < N; k++) ep[k] = !(n >= tp + k * (s + 1));
         ef = n >= lat ? fa : fb;
         es = n <= lat ? 3'd1 : n < tp ? 3'd2 : n < tp + (N - 1) * (s + 1) ? 3'd3 : 3'd4;
         chks++;
         if (por !== ep) begin errs++; $display("FAIL seq_por n=%0d got=%b exp=%b", n, por, ep); end
         chks++;
         if (porb !== ~ep) begin errs++; $display("FAIL seq_porb n=%0d got=%b exp=%b", n, porb, ~ep); end
         chks++;
         if (state !== es) begin errs++; $display("FAIL seq_state n=%0d got=%0d exp=%0d", n, state, es); end
         chks++;
         if (por_timed_out !== (n == tp)) begin
            errs++; $display("FAIL seq_ptm n=%0d got=%b exp=%b", n, por_timed_out, n == tp);
         end
         chks++;
         if (pwup_filt !== ef) begin errs++; $display("FAIL seq_filt n=%0d got=%b exp=%b", n, pwup_filt, ef); end
         chks++;
         if (startup_timed_out !== sto_e) begin
            errs++; $display("FAIL seq_sto n=%0d got=%b exp=%b", n, startup_timed_out, sto_e);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; pwup = 4'h0; ch_en = 4'hF; force_pdn = 1'b0; force_short_oneshot = 1'b0;
      por_dly = 16'd10; stagger_dly = 16'd2; tmo_lim = 20'd1000;
      step();
      step();
      chks++; if (por !== 4'hF) begin errs++; $display("FAIL rst_por got=%b exp=1111", por); end
      chks++; if (porb !== 4'h0) begin errs++; $display("FAIL rst_porb got=%b exp=0000", porb); end
      chks++; if (pwup_filt !== 4'h0) begin errs++; $display("FAIL rst_filt got=%b exp=0000", pwup_filt); end
      chks++; if (state !== 3'd0) begin errs++; $display("FAIL rst_state got=%0d exp=0", state); end
      chks++; if (startup_timed_out !== 1'b0) begin errs++; $display("FAIL rst_sto got=%b exp=0", startup_timed_out); end
      chks++; if (por_timed_out !== 1'b0) begin errs++; $display("FAIL rst_ptm got=%b exp=0", por_timed_out); end
   endtask

   task automatic test_sequence();
      int d, s;
      for (int r = 0; r < 5; r++) begin
         d = r == 0 ? 10 : r == 1 ? 0 : $urandom_range(1, 20);
         s = r == 0 ? 2 : r == 1 ? 0 : $urandom_range(0, 5);
         restart(4'h0);
         por_dly = 16'(d);
         stagger_dly = 16'(s);
         pwup = 4'hF;
         run_seq(F + 2, 4'h0, 4'hF, d, s, F + 3 + (d < 1 ? 1 : d) + (N - 1) * (s + 1) + 2, 1'b0);
      end
   endtask

   task automatic test_glitch();
      logic hist[$];
      logic pat[$];
      logic fm, prev_fm;
      int   n, lens[3];
      lens[0] = 5; lens[1] = $urandom_range(1, F - 1); lens[2] = F;
      restart(4'b1101);
      por_dly = 16'd100;
      for (int i = 0; i < 12; i++) pat.push_back(1'b0);
      for (int j = 0; j < 3; j++) begin
         for (int i = 0; i < lens[j]; i++) pat.push_back(1'b1);
         for (int i = 0; i < 14; i++) pat.push_back(1'b0);
      end
      prev_fm = 1'b0;
      foreach (pat[i]) begin
         pwup[1] = pat[i];
         hist.push_back(pat[i]);
         step();
         n = hist.size();
         fm = n >= F + 2;
         for (int e = n - F - 2; e <= n - 3; e++) if (e >= 0 && !hist[e]) fm = 1'b0;
         chks++;
         if (pwup_filt[1] !== fm) begin errs++; $display("FAIL glitch_filt n=%0d got=%b exp=%b", n, pwup_filt[1], fm); end
         chks++;
         if (state !== (prev_fm ? 3'd2 : 3'd1)) begin
            errs++; $display("FAIL glitch_state n=%0d got=%0d exp=%0d", n, state, prev_fm ? 2 : 1);
         end
         chks++;
         if (por !== 4'hF) begin errs++; $display("FAIL glitch_por n=%0d got=%b exp=1111", n, por); end
         prev_fm = fm;
      end
   endtask

   task automatic test_fault();
      int d, s;
      d = $urandom_range(0, 12);
      s = $urandom_range(0, 4);
      restart(4'h0);
      por_dly = 16'(d);
      stagger_dly = 16'(s);
      pwup = 4'hF;
      run_seq(F + 2, 4'h0, 4'hF, d, s, F + 3 + (d < 1 ? 1 : d) + (N - 1) * (s + 1) + 2, 1'b0);
      pwup[2] = 1'b0;
      for (int n = 1; n <= 5; n++) begin
         step();
         chks++;
         if (por !== (n >= 4 ? 4'hF : 4'h0)) begin
            errs++; $display("FAIL fault_por n=%0d got=%b exp=%b", n, por, n >= 4 ? 4'hF : 4'h0);
         end
         chks++;
         if (state !== (n < 4 ? 3'd4 : n == 4 ? 3'd5 : 3'd1)) begin
            errs++; $display("FAIL fault_state n=%0d got=%0d exp=%0d", n, state, n < 4 ? 4 : n == 4 ? 5 : 1);
         end
      end
      pwup[2] = 1'b1;
      run_seq(F + 2, 4'b1011, 4'hF, d, s, F + 3 + (d < 1 ? 1 : d) + (N - 1) * (s + 1) + 2, 1'b0);
   endtask

   task automatic test_timeout();
      int lim;
      lim = 50;
      restart(4'b0111);
      tmo_lim = 20'(lim);
      for (int n = 2; n <= lim + 3; n++) begin
         step();
         chks++;
         if (startup_timed_out !== (n - 1 >= lim)) begin
            errs++; $display("FAIL tmo_sto n=%0d got=%b exp=%b", n, startup_timed_out, n - 1 >= lim);
         end
         chks++;
         if (state !== 3'd1) begin errs++; $display("FAIL tmo_state n=%0d got=%0d exp=1", n, state); end
      end
      ch_en = 4'b0111;
      run_seq(0, 4'b0111, 4'b0111, 10, 2, 1 + 10 + 3 * 3 + 2, 1'b1);
      force_pdn = 1'b1;
      step();
      chks++; if (state !== 3'd0) begin errs++; $display("FAIL tmo_pdn_state got=%0d exp=0", state); end
      chks++; if (startup_timed_out !== 1'b0) begin errs++; $display("FAIL tmo_pdn_sto got=%b exp=0", startup_timed_out); end
      chks++; if (por !== 4'hF) begin errs++; $display("FAIL tmo_pdn_por got=%b exp=1111", por); end
      step();
      chks++; if (state !== 3'd0) begin errs++; $display("FAIL tmo_pdn_hold got=%0d exp=0", state); end
      force_pdn = 1'b0;
      step();
      chks++; if (state !== 3'd1) begin errs++; $display("FAIL tmo_pdn_rel got=%0d exp=1", state); end
   endtask

   task automatic test_short();
      restart(4'h0);
      force_short_oneshot = 1'b1;
      por_dly = 16'hFFFF;
      stagger_dly = 16'($urandom_range(5, 100));
      pwup = 4'hF;
      run_seq(F + 2, 4'h0, 4'hF, 3, 3, F + 3 + 3 + 4 + 1, 1'b0);
      force_pdn = 1'b1;
      step();
      chks++; if (state !== 3'd0) begin errs++; $display("FAIL short_pdn_state got=%0d exp=0", state); end
      chks++; if (por !== 4'hF) begin errs++; $display("FAIL short_pdn_por got=%b exp=1111", por); end
      chks++; if (por_timed_out !== 1'b0) begin errs++; $display("FAIL short_pdn_ptm got=%b exp=0", por_timed_out); end
      force_pdn = 1'b0;
   endtask

   task automatic test_async_rst();
      int d;
      d = $urandom_range(1, 15);
      restart(4'h0);
      por_dly = 16'(d);
      pwup = 4'hF;
      run_seq(F + 2, 4'h0, 4'hF, d, 2, F + 3 + d + 4, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      chks++; if (por !== 4'hF) begin errs++; $display("FAIL arst_por got=%b exp=1111", por); end
      chks++; if (porb !== 4'h0) begin errs++; $display("FAIL arst_porb got=%b exp=0000", porb); end
      chks++; if (state !== 3'd0) begin errs++; $display("FAIL arst_state got=%0d exp=0", state); end
      chks++; if (pwup_filt !== 4'h0) begin errs++; $display("FAIL arst_filt got=%b exp=0000", pwup_filt); end
      step();
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_sequence();
      test_glitch();
      test_fault();
      test_timeout();
      test_short();
      test_async_rst();
      $display("Result: errors=%0d of %0d checks", errs, chks);
      $finish;
   end
endmodule
